// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite single-port SRAM slave: parametrised wait states, two-cycle ERROR response,
// byte-lane writes and write-to-read forwarding. Optional: `AHB_SRAM_PROT_EN (user-write error).
module ahb3lite_sram_ws #(
    parameter int    HADDR_SIZE  = 16,
    parameter int    HDATA_SIZE  = 32,
    parameter int    MEM_DEPTH   = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);

    localparam int BYTES = HDATA_SIZE / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WW    = HADDR_SIZE - BL;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state, next_state;
    logic [3:0]            wcnt, next_wcnt;
    logic [HADDR_SIZE-1:0] addr_p1;
    logic [2:0]            size_p1;
    logic                  write_p1;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic                  accept, take, prot_err, req_err;
    logic                  beat_write, load_rd, wr_commit, fwd_hit;
    logic [WW-1:0]         req_word;
    logic [AW-1:0]         rd_idx, wr_idx;
    logic [BYTES-1:0]      wr_be;
    logic [HDATA_SIZE-1:0] rd_raw, rd_data;
    logic                  unused_ok;

    function automatic logic [BYTES-1:0] lane_mask(input logic [BL-1:0] lo, input logic [2:0] sz);
        lane_mask = '0;
        for (int i = 0; i < BYTES; i++)
            if (i >= int'(lo) && i < int'(lo) + (1 << sz)) lane_mask[i] = 1'b1;
    endfunction

    function automatic logic misaligned(input logic [BL-1:0] lo, input logic [2:0] sz);
        misaligned = 1'b0;
        for (int i = 0; i < BL; i++)
            if (i < int'(sz) && lo[i]) misaligned = 1'b1;
    endfunction

    function automatic logic [HDATA_SIZE-1:0] merge_lanes(input logic [HDATA_SIZE-1:0] old_w,
                                                          input logic [HDATA_SIZE-1:0] new_w,
                                                          input logic [BYTES-1:0]      be);
        merge_lanes = old_w;
        for (int i = 0; i < BYTES; i++)
            if (be[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
    endfunction

    // Address phase: request decode and legality check
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign take     = accept & (state == S_IDLE || state == S_DATA || state == S_ERR2);
    assign req_word = HADDR[HADDR_SIZE-1:BL];

    always_comb begin
`ifdef AHB_SRAM_PROT_EN
        prot_err = HWRITE & ~HPROT[1];
`else
        prot_err = 1'b0;
`endif
        req_err = (32'(req_word) >= 32'(MEM_DEPTH)) | (HSIZE > 3'(BL))
                | misaligned(HADDR[BL-1:0], HSIZE) | prot_err;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
        end
    end

    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        case (state)
            S_WAIT: begin
                if (wcnt == 4'd1) next_state = S_DATA;
                next_wcnt = wcnt - 4'd1;
            end
            S_ERR1: next_state = S_ERR2;
            default: begin
                if (!take)                 next_state = S_IDLE;
                else if (req_err)          next_state = S_ERR1;
                else if (WAIT_STATES == 0) next_state = S_DATA;
                else begin
                    next_state = S_WAIT;
                    next_wcnt  = 4'(WAIT_STATES);
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_WAIT: HREADYOUT = 1'b0;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    // Data phase: captured request, memory access and forwarding
    always_ff @(posedge HCLK) begin
        if (take) begin
            addr_p1  <= HADDR;
            size_p1  <= HSIZE;
            write_p1 <= HWRITE;
        end
    end

    assign wr_commit  = (state == S_DATA) && write_p1;
    assign wr_idx     = addr_p1[BL +: AW];
    assign wr_be      = lane_mask(addr_p1[BL-1:0], size_p1);
    // A read leaving S_WAIT uses the captured address; a zero-wait read uses the bus address.
    assign beat_write = (state == S_WAIT) ? write_p1 : HWRITE;
    assign rd_idx     = (state == S_WAIT) ? addr_p1[BL +: AW] : HADDR[BL +: AW];
    assign load_rd    = (next_state == S_DATA) && !beat_write;
    assign fwd_hit    = wr_commit && (wr_idx == rd_idx);
    assign rd_raw     = mem[rd_idx];
    assign rd_data    = fwd_hit ? merge_lanes(rd_raw, HWDATA, wr_be) : rd_raw;

    always_ff @(posedge HCLK) begin
        if (wr_commit) mem[wr_idx] <= merge_lanes(mem[wr_idx], HWDATA, wr_be);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     HRDATA <= '0;
        else if (load_rd) HRDATA <= rd_data;
    end

    assign unused_ok = ^{HBURST, HPROT, addr_p1};

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Scoreboard bench for ahb3lite_sram_ws: one zero-wait and one two-wait instance on a shared bus,
// expected beats queued at issue and compared when each data phase completes.
`timescale 1ns/1ps
module tb_ahb3lite_sram_ws;

`ifdef AHB_SRAM_PROT_EN
    localparam logic PROT_ON = 1'b1;
`else
    localparam logic PROT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0, hwrite = 1'b0, act = 1'b0;
    logic [15:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [2:0]  hsize = 3'd2, hburst = 3'd0;
    logic [3:0]  hprot = 4'b0011;
    logic [1:0]  htrans = 2'b00;
    logic        sel0, sel2, rdy0, rdy2, resp0, resp2, rdy_m, resp_m;
    logic [31:0] rd0, rd2, rd_m;

    always #5 clk = ~clk;

    assign sel0   = hsel & ~act;
    assign sel2   = hsel & act;
    assign rdy_m  = act ? rdy2 : rdy0;
    assign resp_m = act ? resp2 : resp0;
    assign rd_m   = act ? rd2 : rd0;

    ahb3lite_sram_ws #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

    ahb3lite_sram_ws #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HREADY(rdy2), .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rd2));

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] mdl [2][256];
    logic        q_rd[$];
    logic        q_er[$];
    logic [31:0] q_dat[$];
    int          q_ws[$];
    string       q_tag[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic pop();
        void'(q_rd.pop_front());
        void'(q_er.pop_front());
        void'(q_dat.pop_front());
        void'(q_ws.pop_front());
        void'(q_tag.pop_front());
    endtask

    task automatic flush();
        while (q_er.size() != 0) pop();
    endtask

    // Issue one NONSEQ beat; returns just after the accepting edge with its HWDATA driven.
    task automatic xfer(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [2:0] sz, input logic [31:0] wdata,
                        input logic [3:0] prot, input logic err);
        logic [31:0] exp_d;
        int          g;
        exp_d = '0;
        g = 0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < (1 << sz); b++) begin
                    int ln;
                    ln = int'(addr[1:0]) + b;
                    mdl[int'(act)][addr[9:2]][8*ln +: 8] = wdata[8*ln +: 8];
                end
            end else begin
                exp_d = mdl[int'(act)][addr[9:2]];
            end
        end
        q_rd.push_back(!wr);
        q_er.push_back(err);
        q_dat.push_back(exp_d);
        q_ws.push_back(err ? 1 : (act ? 2 : 0));
        q_tag.push_back(tag);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = sz; hprot = prot;
        @(negedge clk);
        while (!rdy_m && g < 40) begin
            g++;
            @(negedge clk);
        end
        if (!rdy_m) check({tag, "_accept"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        hwdata = wdata;
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic drain();
        int g;
        g = 0;
        hsel = 1'b0;
        htrans = 2'b00;
        while (q_er.size() != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (q_er.size() != 0) begin
            check("drain_timeout", 32'(q_er.size()), 32'd0);
            flush();
        end
    endtask

    logic dp = 1'b0;
    int   wc = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dp = 1'b0;
            end else begin
                if (dp) begin
                    if (q_er.size() == 0) begin
                        check("sb_empty", 32'd1, 32'd0);
                        dp = 1'b0;
                    end else begin
                        check({q_tag[0], "_hresp"}, 32'(resp_m), 32'(q_er[0]));
                        if (!rdy_m) begin
                            wc++;
                            if (wc > 20) begin
                                check({q_tag[0], "_stuck"}, 32'd0, 32'd1);
                                pop();
                                dp = 1'b0;
                            end
                        end else begin
                            check({q_tag[0], "_waits"}, 32'(wc), 32'(q_ws[0]));
                            if (q_rd[0] && !q_er[0]) check({q_tag[0], "_rdata"}, rd_m, q_dat[0]);
                            pop();
                            dp = 1'b0;
                        end
                    end
                end
                if (rdy_m && hsel && htrans[1]) begin
                    dp = 1'b1;
                    wc = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(rdy0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_ready2", 32'(rdy2), 32'd1);
        check("rst_resp2", 32'(resp2), 32'd0);
        check("rst_rdata2", rd2, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // zero-wait instance: back-to-back write/read with forwarding
        act = 1'b0;
        xfer("t1_wr", 1'b1, 16'h0004, 3'd2, 32'hDEADBEEF, 4'b0011, 1'b0);
        xfer("t1_rd", 1'b0, 16'h0004, 3'd2, 32'h0, 4'b0011, 1'b0);
        xfer("t3_wr_word", 1'b1, 16'h0004, 3'd2, 32'h11223344, 4'b0011, 1'b0);
        xfer("t3_wr_byte", 1'b1, 16'h0005, 3'd0, 32'h0000AA00, 4'b0011, 1'b0);
        xfer("t3_rd_byte", 1'b0, 16'h0004, 3'd2, 32'h0, 4'b0011, 1'b0);
        xfer("t3_wr_half", 1'b1, 16'h0006, 3'd1, 32'hBEEF0000, 4'b0011, 1'b0);
        xfer("t3_rd_half", 1'b0, 16'h0004, 3'd2, 32'h0, 4'b0011, 1'b0);
        xfer("fw_wr_20", 1'b1, 16'h0020, 3'd2, 32'h01020304, 4'b0011, 1'b0);
        xfer("fw_wr_24", 1'b1, 16'h0024, 3'd2, 32'hA0B0C0D0, 4'b0011, 1'b0);
        xfer("fw_rd_20", 1'b0, 16'h0020, 3'd2, 32'h0, 4'b0011, 1'b0);
        drain();

        // error responses and their side effects
        xfer("t4_w0", 1'b1, 16'h0000, 3'd2, 32'h55AA55AA, 4'b0011, 1'b0);
        xfer("t4_err_oob_rd", 1'b0, 16'h0400, 3'd2, 32'h0, 4'b0011, 1'b1);
        xfer("t4_ok_after", 1'b0, 16'h0004, 3'd2, 32'h0, 4'b0011, 1'b0);
        xfer("t4_err_oob_wr", 1'b1, 16'h0400, 3'd2, 32'hFFFFFFFF, 4'b0011, 1'b1);
        xfer("t4_err_misal", 1'b1, 16'h0003, 3'd1, 32'hFFFFFFFF, 4'b0011, 1'b1);
        xfer("t4_err_size3", 1'b1, 16'h0000, 3'd3, 32'hFFFFFFFF, 4'b0011, 1'b1);
        xfer("t4_w0_rb", 1'b0, 16'h0000, 3'd2, 32'h0, 4'b0011, 1'b0);
        drain();

        // IDLE and BUSY with HSEL high: no data phase, no write
        hsel = 1'b1; hwrite = 1'b1; haddr = 16'h0004; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            htrans = (i < 2) ? 2'b00 : 2'b01;
            @(negedge clk);
            check("t5_idle_busy_ready", 32'(rdy0), 32'd1);
            check("t5_idle_busy_resp", 32'(resp0), 32'd0);
            @(posedge clk);
            #1;
        end
        hsel = 1'b0; htrans = 2'b00;
        xfer("t5_rb", 1'b0, 16'h0004, 3'd2, 32'h0, 4'b0011, 1'b0);

        // user-mode write protection
        xfer("t6_wr_priv", 1'b1, 16'h0010, 3'd2, 32'hCAFE0001, 4'b0011, 1'b0);
        xfer("t6_wr_user", 1'b1, 16'h0010, 3'd2, 32'h0BADF00D, 4'b0001, PROT_ON);
        xfer("t6_rd_user", 1'b0, 16'h0010, 3'd2, 32'h0, 4'b0001, 1'b0);
        xfer("t6_wr_priv2", 1'b1, 16'h0010, 3'd2, 32'h600DCAFE, 4'b0011, 1'b0);
        xfer("t6_rd_priv2", 1'b0, 16'h0010, 3'd2, 32'h0, 4'b0011, 1'b0);
        drain();

        // two-wait instance
        act = 1'b1;
        xfer("t2_wr8", 1'b1, 16'h0008, 3'd2, 32'h12345678, 4'b0011, 1'b0);
        xfer("t2_rd8", 1'b0, 16'h0008, 3'd2, 32'h0, 4'b0011, 1'b0);
        xfer("ws2_err_oob", 1'b0, 16'h0400, 3'd2, 32'h0, 4'b0011, 1'b1);
        xfer("ws2_wr_c", 1'b1, 16'h000C, 3'd2, 32'hA5A5A5A5, 4'b0011, 1'b0);
        xfer("ws2_wr_c_b", 1'b1, 16'h000F, 3'd0, 32'h3C000000, 4'b0011, 1'b0);
        xfer("ws2_rd_c", 1'b0, 16'h000C, 3'd2, 32'h0, 4'b0011, 1'b0);
        drain();

        // reset asserted in the middle of a wait phase
        xfer("rst_mid_rd", 1'b0, 16'h0008, 3'd2, 32'h0, 4'b0011, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(rdy2), 32'd1);
        check("rst_mid_resp", 32'(resp2), 32'd0);
        check("rst_mid_rdata", rd2, 32'd0);
        @(negedge clk);
        #1 flush();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer("rst_after_rd8", 1'b0, 16'h0008, 3'd2, 32'h0, 4'b0011, 1'b0);
        xfer("rst_after_rd_c", 1'b0, 16'h000C, 3'd2, 32'h0, 4'b0011, 1'b0);
        drain();
        act = 1'b0;
        xfer("rst_after_rd4", 1'b0, 16'h0004, 3'd2, 32'h0, 4'b0011, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
